// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate / load-data extender with valid/ready handshake and flush.
// Extension is combinational at the input; STAGES register stages follow, tail drives outputs.
module ext_pipe #(
   parameter int unsigned IMM_W     = 16,
   parameter int unsigned STAGES    = 1,
   parameter int unsigned SHAMT_LSB = 6,
   parameter int unsigned SHAMT_W   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       iop,
   input  logic [IMM_W-1:0] imm,
   input  logic [31:0]      din,
   input  logic [1:0]       addr,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      o32,
   output logic             err
);

   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic [SHAMT_W-1:0] shamt;
   logic [31:0]        ext_data;
   logic               ext_err;
   logic               advance;
   logic               xfer;

   logic [STAGES-1:0]        valid_q, valid_d;
   logic [STAGES-1:0]        err_q, err_d;
   logic [STAGES-1:0][31:0]  data_q, data_d;

   assign byte_sel = din[{addr, 3'b000} +: 8];
   assign half_sel = addr[1] ? din[31:16] : din[15:0];
   assign shamt    = imm[SHAMT_LSB +: SHAMT_W];

   // Decode the mode and extend the selected operand
   always_comb begin
      ext_data = '0;
      ext_err  = 1'b0;
      case (iop)
         3'd0: ext_data = {{(32-IMM_W){1'b0}}, imm};
         3'd1: ext_data = {{(32-IMM_W){imm[IMM_W-1]}}, imm};
         3'd2: ext_data = {imm, {(32-IMM_W){1'b0}}};
         3'd3: ext_data = {{(32-SHAMT_W){1'b0}}, shamt};
         3'd4: ext_data = {{24{byte_sel[7]}}, byte_sel};
         3'd5: ext_data = {24'h0, byte_sel};
         3'd6: begin
            // Odd address on a halfword load: result forced to zero and flagged
            if (addr[0]) ext_err = 1'b1;
            else         ext_data = {{16{half_sel[15]}}, half_sel};
         end
         3'd7: begin
            if (addr[0]) ext_err = 1'b1;
            else         ext_data = {16'h0, half_sel};
         end
         default: ext_data = '0;
      endcase
   end

   // The whole pipe stalls only when the tail holds a result nobody takes
   assign advance  = !(out_valid && !out_ready);
   assign in_ready = advance;
   assign xfer     = in_valid && advance && !flush;

   // Next-state for all stages: flush clears, advance shifts, otherwise hold
   always_comb begin
      valid_d = valid_q;
      err_d   = err_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = '0;
         err_d   = '0;
         data_d  = '0;
      end else if (advance) begin
         valid_d[0] = xfer;
         err_d[0]   = xfer ? ext_err  : 1'b0;
         data_d[0]  = xfer ? ext_data : 32'h0;
         for (int k = 1; k < int'(STAGES); k++) begin
            valid_d[k] = valid_q[k-1];
            err_d[k]   = err_q[k-1];
            data_d[k]  = data_q[k-1];
         end
      end
   end

   // Stage registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         err_q   <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign err       = err_q[STAGES-1];
   assign o32       = data_q[STAGES-1];

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: a 2-stage 16-bit instance and a 4-stage 12-bit instance.
module tb_ext_pipe;

   localparam int STG  = 2;
   localparam int STG4 = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, flush, out_valid, out_ready, err;
   logic [2:0]  iop;
   logic [15:0] imm;
   logic [31:0] din, o32;
   logic [1:0]  addr;

   logic        p_in_valid, p_in_ready, p_flush, p_out_valid, p_out_ready, p_err;
   logic [2:0]  p_iop;
   logic [11:0] p_imm;
   logic [31:0] p_din, p_o32;
   logic [1:0]  p_addr;

   typedef struct {
      logic [2:0]  iop;
      logic [15:0] imm;
      logic [31:0] din;
      logic [1:0]  addr;
      logic [31:0] d;
      logic        e;
   } req_t;

   typedef struct {
      logic [31:0] d;
      logic        e;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ext_pipe #(.IMM_W(16), .STAGES(STG), .SHAMT_LSB(6), .SHAMT_W(5)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .iop(iop),
      .imm(imm), .din(din), .addr(addr), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .o32(o32), .err(err)
   );

   ext_pipe #(.IMM_W(12), .STAGES(STG4), .SHAMT_LSB(6), .SHAMT_W(5)) dut4 (
      .clk(clk), .reset(reset), .in_valid(p_in_valid), .in_ready(p_in_ready), .iop(p_iop),
      .imm(p_imm), .din(p_din), .addr(p_addr), .flush(p_flush), .out_valid(p_out_valid),
      .out_ready(p_out_ready), .o32(p_o32), .err(p_err)
   );

   function automatic req_t mk(input logic [2:0] i_iop, input logic [15:0] i_imm,
                               input logic [31:0] i_din, input logic [1:0] i_addr,
                               input logic [31:0] e_d, input logic e_e);
      req_t r;
      r.iop = i_iop; r.imm = i_imm; r.din = i_din; r.addr = i_addr; r.d = e_d; r.e = e_e;
      return r;
   endfunction

   task automatic drive(input req_t r);
      in_valid = 1'b1;
      iop      = r.iop;
      imm      = r.imm;
      din      = r.din;
      addr     = r.addr;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({out_valid, err, o32, in_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_a: got v=%b e=%b o32=%h rdy=%b, want v=0 e=0 o32=0 rdy=1",
                  out_valid, err, o32, in_ready);
      end
      n_checks++;
      if ({p_out_valid, p_err, p_o32, p_in_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_p: got v=%b e=%b o32=%h rdy=%b, want v=0 e=0 o32=0 rdy=1",
                  p_out_valid, p_err, p_o32, p_in_ready);
      end
   endtask

   task automatic test_imm();
      req_t r[$];
      exp_t e;
      int   k = 0;
      r.push_back(mk(3'd0, 16'h8001, 32'hDEADBEEF, 2'd3, 32'h00008001, 1'b0));
      r.push_back(mk(3'd1, 16'h8001, 32'hDEADBEEF, 2'd1, 32'hFFFF8001, 1'b0));
      r.push_back(mk(3'd2, 16'h8001, 32'h0, 2'd0, 32'h80010000, 1'b0));
      r.push_back(mk(3'd3, 16'h07C0, 32'h0, 2'd0, 32'h0000001F, 1'b0));
      r.push_back(mk(3'd1, 16'h7FFF, 32'h0, 2'd0, 32'h00007FFF, 1'b0));
      out_ready = 1'b1;
      for (int i = 0; i < 40 && (k < r.size() || sb.size() != 0); i++) begin
         @(negedge clk);
         if (out_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL imm_spurious: got o32=%h with nothing expected", o32);
            end else begin
               e = sb.pop_front();
               if ({err, o32} !== {e.e, e.d} || cyc - e.cyc != STG) begin
                  n_fail++;
                  $display("FAIL imm: got err=%b o32=%h lat=%0d, want err=%b o32=%h lat=%0d",
                           err, o32, cyc - e.cyc, e.e, e.d, STG);
               end
            end
         end
         if (k < r.size()) begin
            drive(r[k]);
            sb.push_back('{d: r[k].d, e: r[k].e, cyc: cyc});
            k++;
         end else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      n_checks++;
      if (sb.size() != 0 || k != r.size()) begin
         n_fail++;
         $display("FAIL imm_drain: got %0d pending %0d sent, want 0 pending %0d sent",
                  sb.size(), k, r.size());
      end
      sb.delete();
   endtask

   task automatic test_loads();
      req_t r[$];
      exp_t e;
      int   k = 0;
      r.push_back(mk(3'd4, 16'hFFFF, 32'h12F4_5680, 2'd0, 32'hFFFFFF80, 1'b0));
      r.push_back(mk(3'd4, 16'h0, 32'h12F4_5680, 2'd1, 32'h00000056, 1'b0));
      r.push_back(mk(3'd4, 16'h0, 32'h12F4_5680, 2'd2, 32'hFFFFFFF4, 1'b0));
      r.push_back(mk(3'd4, 16'h0, 32'h12F4_5680, 2'd3, 32'h00000012, 1'b0));
      r.push_back(mk(3'd5, 16'h0, 32'h12F4_5680, 2'd0, 32'h00000080, 1'b0));
      r.push_back(mk(3'd5, 16'h0, 32'h12F4_5680, 2'd1, 32'h00000056, 1'b0));
      r.push_back(mk(3'd5, 16'h0, 32'h12F4_5680, 2'd2, 32'h000000F4, 1'b0));
      r.push_back(mk(3'd5, 16'h0, 32'h12F4_5680, 2'd3, 32'h00000012, 1'b0));
      r.push_back(mk(3'd6, 16'h0, 32'h8000_7FFF, 2'd0, 32'h00007FFF, 1'b0));
      r.push_back(mk(3'd6, 16'h0, 32'h8000_7FFF, 2'd2, 32'hFFFF8000, 1'b0));
      r.push_back(mk(3'd7, 16'h0, 32'h8000_7FFF, 2'd2, 32'h00008000, 1'b0));
      r.push_back(mk(3'd6, 16'h0, 32'h8000_7FFF, 2'd1, 32'h00000000, 1'b1));
      r.push_back(mk(3'd7, 16'h0, 32'h8000_7FFF, 2'd3, 32'h00000000, 1'b1));
      r.push_back(mk(3'd7, 16'h0, 32'h8000_7FFF, 2'd0, 32'h00007FFF, 1'b0));
      out_ready = 1'b1;
      for (int i = 0; i < 60 && (k < r.size() || sb.size() != 0); i++) begin
         @(negedge clk);
         if (out_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL load_spurious: got o32=%h with nothing expected", o32);
            end else begin
               e = sb.pop_front();
               if ({err, o32} !== {e.e, e.d} || cyc - e.cyc != STG) begin
                  n_fail++;
                  $display("FAIL load: got err=%b o32=%h lat=%0d, want err=%b o32=%h lat=%0d",
                           err, o32, cyc - e.cyc, e.e, e.d, STG);
               end
            end
         end
         if (k < r.size()) begin
            drive(r[k]);
            sb.push_back('{d: r[k].d, e: r[k].e, cyc: cyc});
            k++;
         end else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      n_checks++;
      if (sb.size() != 0 || k != r.size()) begin
         n_fail++;
         $display("FAIL load_drain: got %0d pending %0d sent, want 0 pending %0d sent",
                  sb.size(), k, r.size());
      end
      sb.delete();
   endtask

   task automatic test_backpressure();
      req_t r[$];
      int   k      = 0;
      int   stalls = 0;
      r.push_back(mk(3'd0, 16'h1111, 32'h0, 2'd0, 32'h00001111, 1'b0));
      r.push_back(mk(3'd1, 16'h9222, 32'h0, 2'd0, 32'hFFFF9222, 1'b0));
      r.push_back(mk(3'd5, 16'h0, 32'hAABBCCDD, 2'd2, 32'h000000BB, 1'b0));
      r.push_back(mk(3'd7, 16'h0, 32'hAABBCCDD, 2'd1, 32'h00000000, 1'b1));
      for (int i = 0; i < 40 && (k < r.size() || sb.size() != 0); i++) begin
         @(negedge clk);
         out_ready = !(i >= 2 && i <= 4);
         #1;
         n_checks++;
         if (out_valid && !out_ready) begin
            stalls++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL bp_in_ready_stall: got %b want 0", in_ready);
            end
         end else if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_in_ready_free: got %b want 1", in_ready);
         end
         if (out_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL bp_spurious: got o32=%h with nothing expected", o32);
            end else begin
               if ({err, o32} !== {sb[0].e, sb[0].d}) begin
                  n_fail++;
                  $display("FAIL bp_data: got err=%b o32=%h, want err=%b o32=%h",
                           err, o32, sb[0].e, sb[0].d);
               end
               if (out_ready) void'(sb.pop_front());
            end
         end
         if (k < r.size()) begin
            drive(r[k]);
            if (in_ready) begin
               sb.push_back('{d: r[k].d, e: r[k].e, cyc: cyc});
               k++;
            end
         end else in_valid = 1'b0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_checks++;
      if (stalls != 3 || sb.size() != 0 || k != r.size()) begin
         n_fail++;
         $display("FAIL bp_summary: got stalls=%0d pending=%0d sent=%0d, want 3 0 %0d",
                  stalls, sb.size(), k, r.size());
      end
      sb.delete();
   endtask

   // kind 0 = flush, kind 1 = reset
   task automatic test_flush_reset(input int kind);
      out_ready = 1'b1;
      @(negedge clk);
      drive(mk(3'd6, 16'h0, 32'h8000_7FFF, 2'd1, 32'h0, 1'b1));
      @(negedge clk);
      drive(mk(3'd0, 16'h1234, 32'h0, 2'd0, 32'h00001234, 1'b0));
      @(negedge clk);
      n_checks++;
      if ({out_valid, err} !== 2'b11) begin
         n_fail++;
         $display("FAIL inflight_%0d: got v=%b e=%b want v=1 e=1", kind, out_valid, err);
      end
      drive(mk(3'd2, 16'hABCD, 32'h0, 2'd0, 32'hABCD0000, 1'b0));
      if (kind == 0) flush = 1'b1;
      else begin
         reset     = 1'b1;
         out_ready = 1'b0;
      end
      @(negedge clk);
      flush    = 1'b0;
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, err, o32, in_ready} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL clear_%0d: got v=%b e=%b o32=%h rdy=%b want v=0 e=0 o32=0 rdy=1",
                  kind, out_valid, err, o32, in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dropped_%0d: got out_valid=%b o32=%h want 0", kind, out_valid, o32);
         end
      end
      out_ready = 1'b1;
   endtask

   task automatic test_param();
      exp_t e;
      int   seen = 0;
      p_out_ready = 1'b1;
      @(negedge clk);
      p_in_valid = 1'b1; p_iop = 3'd1; p_imm = 12'h800;
      sb.push_back('{d: 32'hFFFFF800, e: 1'b0, cyc: cyc});
      @(negedge clk);
      p_iop = 3'd2;
      sb.push_back('{d: 32'h80000000, e: 1'b0, cyc: cyc});
      @(negedge clk);
      p_in_valid = 1'b0;
      for (int i = 0; i < 12 && sb.size() != 0; i++) begin
         if (p_out_valid) begin
            e = sb.pop_front();
            seen++;
            n_checks++;
            if ({p_err, p_o32} !== {e.e, e.d} || cyc - e.cyc != STG4) begin
               n_fail++;
               $display("FAIL param: got err=%b o32=%h lat=%0d, want err=%b o32=%h lat=%0d",
                        p_err, p_o32, cyc - e.cyc, e.e, e.d, STG4);
            end
         end
         @(negedge clk);
      end
      n_checks++;
      if (seen != 2) begin
         n_fail++;
         $display("FAIL param_count: got %0d results want 2", seen);
      end
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; iop = '0; imm = '0; din = '0; addr = '0;
      flush = 1'b0; out_ready = 1'b1;
      p_in_valid = 1'b0; p_iop = '0; p_imm = '0; p_din = '0; p_addr = '0;
      p_flush = 1'b0; p_out_ready = 1'b1;
      test_reset();
      test_imm();
      test_loads();
      test_backpressure();
      test_flush_reset(0);
      test_flush_reset(1);
      test_param();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
